regfile_32x64: RTL



---
 rtl/regfile_pkg.sv | 17 +
 rtl/decoder5_32.sv | 18 +
 rtl/regfile_32x64.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and the pipeline stages.
// The same package is imported by decode, write-back and the register file itself.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == ADDR_W'(ZERO_REG);
  endfunction

endpackage

// File: rtl/decoder5_32.sv
// One-hot decode of the write-back destination address into per-register enables.
// The output is all zeros whenever wr_en is low.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [NREGS-1:0]  wr_onehot
);

  always_comb begin
    wr_onehot = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_onehot[i] = wr_en && (wr_addr == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/regfile_32x64.sv
// 32 x 64-bit register file: two combinational read ports, one synchronous write port, X31 reads zero.
// Optional same-cycle write-to-read bypass is compiled in with `define REGFILE_BYPASS_EN.
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wr_busy
);

  // ZERO_REG is the top index, so storage covers only registers 0..NREGS-2.
  localparam int NSTORE = NREGS - 1;

  logic [NREGS-1:0] dec_en;
  logic [NREGS-1:0] wr_en_vec;
  reg_data_t        regs_q [NSTORE];
  reg_data_t        regs_d [NSTORE];
  logic             wr_busy_q;
  logic             wr_busy_d;
  reg_data_t        rd_a;
  reg_data_t        rd_b;

  decoder5_32 u_decoder (
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_onehot (dec_en)
  );

  always_comb begin
    wr_en_vec           = dec_en;
    wr_en_vec[ZERO_REG] = 1'b0;
    for (int i = 0; i < NSTORE; i++) begin
      regs_d[i] = wr_en_vec[i] ? wr_data : regs_q[i];
    end
    wr_busy_d = |wr_en_vec;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NSTORE; i++) begin
        regs_q[i] <= '0;
      end
      wr_busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NSTORE; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wr_busy_q <= wr_busy_d;
    end
  end

  // Read muxes default to zero, which is also what an access to ZERO_REG returns.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NSTORE; i++) begin
      if (rd_addr_a == ADDR_W'(i)) rd_a = regs_q[i];
      if (rd_addr_b == ADDR_W'(i)) rd_b = regs_q[i];
    end
`ifdef REGFILE_BYPASS_EN
    if (reset_n && wr_en && !is_zero_reg(wr_addr)) begin
      if (rd_addr_a == wr_addr) rd_a = wr_data;
      if (rd_addr_b == wr_addr) rd_b = wr_data;
    end
`endif
  end

  assign rd_data_a = rd_a;
  assign rd_data_b = rd_b;
  assign wr_busy   = wr_busy_q;

endmodule
